mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS core. Decodes the 6-bit opcode held in the instruction register and sequences the datapath through fetch/decode/execute/memory/writeback steps. Drives `aluop[1:0]` directly into the ALU decoder (00 = add, 01 = sub, 10 = use funct). Stalls on a memory ready handshake.

Parameters:
- `MEM_HANDSHAKE`, default 1: 1 = FETCH/MEMRD/MEMWR wait for `mem_ready`; 0 = `mem_ready` ignored (treated as 1).

Ports:
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `op`  in  6  opcode field from instruction register
- `mem_ready`  in  1  memory access completes this cycle
- `pcwrite`  out  1  unconditional PC write enable
- `branch`  out  1  PC write if ALU zero (datapath forms pcen)
- `pcsrc`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut
- `memwrite`  out  1  memory write strobe
- `irwrite`  out  1  instruction register load
- `regdst`  out  1  1 = rd, 0 = rt
- `memtoreg`  out  1  1 = data register, 0 = ALUOut
- `regwrite`  out  1  register file write
- `alusrca`  out  1  0 = PC, 1 = A
- `alusrcb`  out  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2
- `aluop`  out  2  to ALU decoder
- `illegal_op`  out  1  sticky illegal-opcode flag (see Optional Feature; tied 0 otherwise)
- `state_dbg`  out  4  current state encoding

Behaviour:
- Moore FSM, 4-bit state register updated on posedge `clk`. All outputs are decoded combinationally from state; the only exception is handshake gating of `pcwrite`/`irwrite`/`memwrite`.
- Reset (`reset_n` = 0, async, mid-instruction included):
  - state = FETCH, `illegal_op` = 0.
  - All write enables (`pcwrite`, `irwrite`, `memwrite`, `regwrite`, `branch`) forced 0 while reset is asserted.
  - Other outputs hold FETCH values: `iord` 0, `alusrca` 0, `alusrcb` 01, `aluop` 00, `pcsrc` 00, `regdst` 0, `memtoreg` 0.
- Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
- States, asserted signals (unlisted = 0) and transitions:
  - FETCH: `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00. `irwrite` = `pcwrite` = `mem_ready`. -> DECODE if `mem_ready`, else stay.
  - DECODE: `alusrca`=0, `alusrcb`=11, `aluop`=00. Next state by op:
    - LW/SW -> MEMADR
    - RTYPE -> RTYPEEX
    - BEQ -> BEQEX
    - ADDI -> ADDIEX
    - J -> JEX
    - other -> see Optional Feature
  - MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=00. -> MEMRD if LW, MEMWR if SW.
  - MEMRD: `iord`=1. -> MEMWB on `mem_ready`, else stay.
  - MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1. -> FETCH.
  - MEMWR: `iord`=1, `memwrite`=`mem_ready`. -> FETCH on `mem_ready`, else stay. Memory must accept the write in the `mem_ready` cycle only.
  - RTYPEEX: `alusrca`=1, `alusrcb`=00, `aluop`=10. -> RTYPEWB.
  - RTYPEWB: `regdst`=1, `memtoreg`=0, `regwrite`=1. -> FETCH.
  - BEQEX: `alusrca`=1, `alusrcb`=00, `aluop`=01, `branch`=1, `pcsrc`=01. -> FETCH.
  - ADDIEX: `alusrca`=1, `alusrcb`=10, `aluop`=00. -> ADDIWB.
  - ADDIWB: `regdst`=0, `memtoreg`=0, `regwrite`=1. -> FETCH.
  - JEX: `pcwrite`=1, `pcsrc`=10. -> JEX to FETCH.
- Latency with `mem_ready` tied 1: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3 cycles. Each cycle of `mem_ready` = 0 in FETCH/MEMRD/MEMWR adds one cycle.
- `op` is sampled only in DECODE and MEMADR; changes in other states have no effect.
- Unreachable state encodings -> FETCH next cycle, all enables 0.

Optional Feature:
- Macro: `MIPS_CTRL_ILLEGAL_TRAP_EN`.
- Defined: unknown op in DECODE -> TRAP state.
  - TRAP: all enables 0, `illegal_op` = 1, stays in TRAP until reset.
  - `illegal_op` is cleared only by reset.
- Undefined: unknown op in DECODE -> FETCH (instruction executes as NOP, PC already advanced). No TRAP state exists; `illegal_op` is tied 0.

Decomposition:
- Package `mips_ctrl_pkg`:
  - state enum `ctrl_state_t` (4-bit)
  - opcode localparams (`OP_LW`, `OP_SW`, `OP_RTYPE`, `OP_BEQ`, `OP_ADDI`, `OP_J`)
  - aluop constants (`ALUOP_ADD`=00, `ALUOP_SUB`=01, `ALUOP_FUNCT`=10)
  - alusrcb and pcsrc encodings
- Single module; no sub-module. Next-state logic and output decode are separate `always_comb` blocks.

Test Plan:
- Reset mid-MEMRD (assert `reset_n`=0 for 2 cycles) -> `state_dbg`=FETCH, `regwrite`/`memwrite`/`pcwrite`=0 during reset; after release, FETCH outputs `alusrcb`=01, `aluop`=00.
- op=100011, `mem_ready`=1 -> exactly 5 cycles FETCH, DECODE, MEMADR, MEMRD, MEMWB; `regwrite`=1 and `memtoreg`=1 only in cycle 5.
- op=000000 -> `aluop`=10 in RTYPEEX; `regdst`=1 and `regwrite`=1 in RTYPEWB; 4-cycle instruction.
- op=101011 with `mem_ready` low for 3 cycles in MEMWR -> `memwrite` pulses for exactly 1 cycle, on the cycle `mem_ready`=1; instruction totals 7 cycles.
- op=000100 -> BEQEX: `aluop`=01, `branch`=1, `pcsrc`=01, `pcwrite`=0; back to FETCH after 3 cycles.
- op=111111:
  - with `MIPS_CTRL_ILLEGAL_TRAP_EN` -> TRAP, `illegal_op`=1 held, no enables until reset.
  - without -> FETCH follows DECODE, `illegal_op`=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// The TRAP state exists only when MIPS_CTRL_ILLEGAL_TRAP_EN is defined.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    JEX     = 4'd11,
    TRAP    = 4'd12
`else
    JEX     = 4'd11
`endif
  } ctrl_state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in, control strobes out.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       branch;
  logic [1:0] pcsrc;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    input  op, mem_ready,
    output pcwrite, branch, pcsrc, iord, memwrite, irwrite, regdst, memtoreg,
           regwrite, alusrca, alusrcb, aluop, illegal_op, state_dbg
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, branch, pcsrc, iord, memwrite, irwrite, regdst, memtoreg,
           regwrite, alusrca, alusrcb, aluop, illegal_op, state_dbg
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main Moore control FSM of the multicycle MIPS core.
// Optional sticky illegal-opcode trap enabled by MIPS_CTRL_ILLEGAL_TRAP_EN.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input logic                    clk,
  input logic                    reset_n,
  mips_multicycle_ctrl_if.master bus
);

  ctrl_state_t state_q, state_d;
  logic        mem_ok_s;
  logic        pcwrite_s, branch_s, iord_s, memwrite_s, irwrite_s;
  logic        regdst_s, memtoreg_s, regwrite_s, alusrca_s;
  logic [1:0]  pcsrc_s, alusrcb_s, aluop_s;

  assign mem_ok_s = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; op only matters in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: begin
        if (mem_ok_s) state_d = DECODE;
        else          state_d = FETCH;
      end
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        if (bus.op == OP_LW)      state_d = MEMRD;
        else if (bus.op == OP_SW) state_d = MEMWR;
        else                      state_d = FETCH;
      end
      MEMRD: begin
        if (mem_ok_s) state_d = MEMWB;
        else          state_d = MEMRD;
      end
      MEMWR: begin
        if (mem_ok_s) state_d = FETCH;
        else          state_d = MEMWR;
      end
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      TRAP:    state_d = TRAP;
`endif
      default: state_d = FETCH;
    endcase
  end

  // Output decode from state; only the memory strobes look at the handshake.
  always_comb begin
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    pcsrc_s    = PCSRC_ALU;
    iord_s     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst_s   = 1'b0;
    memtoreg_s = 1'b0;
    regwrite_s = 1'b0;
    alusrca_s  = 1'b0;
    alusrcb_s  = ALUSRCB_B;
    aluop_s    = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        alusrcb_s = ALUSRCB_FOUR;
        irwrite_s = mem_ok_s;
        pcwrite_s = mem_ok_s;
      end
      DECODE: alusrcb_s = ALUSRCB_IMMSH;
      MEMADR, ADDIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = ALUSRCB_IMM;
      end
      MEMRD: iord_s = 1'b1;
      MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = mem_ok_s;
      end
      RTYPEEX: begin
        alusrca_s = 1'b1;
        aluop_s   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
      end
      BEQEX: begin
        alusrca_s = 1'b1;
        aluop_s   = ALUOP_SUB;
        branch_s  = 1'b1;
        pcsrc_s   = PCSRC_ALUOUT;
      end
      ADDIWB: regwrite_s = 1'b1;
      JEX: begin
        pcwrite_s = 1'b1;
        pcsrc_s   = PCSRC_JUMP;
      end
      default: pcwrite_s = 1'b0;
    endcase
  end

  // Write enables are held low for as long as reset is asserted.
  assign bus.pcwrite   = pcwrite_s  & reset_n;
  assign bus.branch    = branch_s   & reset_n;
  assign bus.memwrite  = memwrite_s & reset_n;
  assign bus.irwrite   = irwrite_s  & reset_n;
  assign bus.regwrite  = regwrite_s & reset_n;
  assign bus.pcsrc     = pcsrc_s;
  assign bus.iord      = iord_s;
  assign bus.regdst    = regdst_s;
  assign bus.memtoreg  = memtoreg_s;
  assign bus.alusrca   = alusrca_s;
  assign bus.alusrcb   = alusrcb_s;
  assign bus.aluop     = aluop_s;
  assign bus.state_dbg = state_q;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  logic illegal_op_q, illegal_op_d;

  // Sticky flag, set on entry to TRAP.
  always_comb begin
    illegal_op_d = illegal_op_q | (state_d == TRAP);
  end

  // Illegal-opcode flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_op_q <= 1'b0;
    end else begin
      illegal_op_q <= illegal_op_d;
    end
  end

  assign bus.illegal_op = illegal_op_q;
`else
  assign bus.illegal_op = 1'b0;
`endif

endmodule
